// File: rtl/vu_meter_multi.sv
// Multi-channel VU meter: per-channel windowed average or peak-hold level
// with per-window decay, driving a glitch-free PWM output per channel.
module vu_meter_multi #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned SAMPLE_W     = 8,
    parameter int unsigned AVG_LOG2     = 4,
    parameter int unsigned PWM_W        = 7,
    parameter int unsigned PWM_PRESCALE = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       audio_clk_enable,
    input  logic                       audio_enable,
    input  logic                       mode,
    input  logic [NUM_CH*SAMPLE_W-1:0] audio_samples,
    output logic [NUM_CH-1:0]          vu_pwm,
    output logic [NUM_CH*PWM_W-1:0]    level,
    output logic                       level_valid
);

    localparam int unsigned MAG_W = SAMPLE_W - 1;
    localparam int unsigned ACC_W = MAG_W + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);

    logic [CNT_W-1:0] win_cnt;
    logic             qual;
    logic             win_close;
    logic [PRE_W-1:0] presc;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] pwm_cnt_nxt;
    logic             pre_wrap;
    logic             period_wrap;

    // Shared strobe qualification and PWM timebase decode
    always_comb begin
        qual        = audio_clk_enable & audio_enable;
        win_close   = qual && (win_cnt == WIN_LAST);
        pre_wrap    = (presc == PRE_LAST);
        period_wrap = pre_wrap && (pwm_cnt == '1);
        pwm_cnt_nxt = pre_wrap ? pwm_cnt + PWM_W'(1) : pwm_cnt;
    end

    // Window sample counter; disable clears it and drops a coincident strobe
    always_ff @(posedge clk) begin
        if (reset || !audio_enable) begin
            win_cnt <= '0;
        end else if (win_close) begin
            win_cnt <= '0;
        end else if (qual) begin
            win_cnt <= win_cnt + CNT_W'(1);
        end
    end

    // One-cycle pulse in the cycle the new level becomes visible
    always_ff @(posedge clk) begin
        if (reset) begin
            level_valid <= 1'b0;
        end else begin
            level_valid <= win_close;
        end
    end

    // Free-running PWM prescaler and period counter (not affected by enable)
    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= pre_wrap ? '0 : presc + PRE_W'(1);
            pwm_cnt <= pwm_cnt_nxt;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
        logic [SAMPLE_W-1:0] smp;
        logic [MAG_W-1:0]    mag;
        logic [MAG_W-1:0]    peak_q;
        logic [MAG_W-1:0]    peak_c;
        logic [MAG_W-1:0]    result;
        logic [ACC_W-1:0]    acc_q;
        logic [ACC_W-1:0]    sum_c;
        logic [PWM_W-1:0]    new_lvl;
        logic [PWM_W-1:0]    lvl_q;
        logic [PWM_W-1:0]    lvl_nxt;
        logic [PWM_W-1:0]    duty_q;
        logic [PWM_W-1:0]    duty_nxt;
        logic                pwm_q;

        // Magnitude, window result and next meter level for this channel
        always_comb begin
            smp = audio_samples[c*SAMPLE_W +: SAMPLE_W];
            if (smp[SAMPLE_W-1] && (smp[MAG_W-1:0] == '0)) begin
                mag = '1;
            end else if (smp[SAMPLE_W-1]) begin
                mag = ~smp[MAG_W-1:0] + MAG_W'(1);
            end else begin
                mag = smp[MAG_W-1:0];
            end
            sum_c   = acc_q + ACC_W'(mag);
            peak_c  = (mag > peak_q) ? mag : peak_q;
            result  = mode ? peak_c : sum_c[ACC_W-1 -: MAG_W];
            new_lvl = result[MAG_W-1 -: PWM_W];
            if (!mode || (new_lvl >= lvl_q)) begin
                lvl_nxt = new_lvl;
            end else if (lvl_q != '0) begin
                lvl_nxt = lvl_q - PWM_W'(1);
            end else begin
                lvl_nxt = '0;
            end
            duty_nxt = period_wrap ? lvl_q : duty_q;
        end

        // Accumulate/peak within a window and commit the level at window close
        always_ff @(posedge clk) begin
            if (reset || !audio_enable) begin
                acc_q  <= '0;
                peak_q <= '0;
                lvl_q  <= '0;
            end else if (win_close) begin
                acc_q  <= '0;
                peak_q <= '0;
                lvl_q  <= lvl_nxt;
            end else if (qual) begin
                acc_q  <= sum_c;
                peak_q <= peak_c;
            end
        end

        // Duty latched only at period start; output compares against next count
        always_ff @(posedge clk) begin
            if (reset) begin
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else begin
                duty_q <= duty_nxt;
                pwm_q  <= (pwm_cnt_nxt < duty_nxt);
            end
        end

        assign level[c*PWM_W +: PWM_W] = lvl_q;
        assign vu_pwm[c]               = pwm_q;
    end

endmodule

// File: tb/tb_vu_meter_multi.sv
// Directed bench for vu_meter_multi at default parameters.
module tb_vu_meter_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        audio_clk_enable;
    logic        audio_enable;
    logic        mode;
    logic [15:0] audio_samples;
    logic [1:0]  vu_pwm;
    logic [13:0] level;
    logic        level_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hi0 = 0;
    int lo1 = 0;
    int vcnt = 0;

    vu_meter_multi dut (
        .clk              (clk),
        .reset            (reset),
        .audio_clk_enable (audio_clk_enable),
        .audio_enable     (audio_enable),
        .mode             (mode),
        .audio_samples    (audio_samples),
        .vu_pwm           (vu_pwm),
        .level            (level),
        .level_valid      (level_valid)
    );

    always #5 clk = ~clk;

    // Cycle counter and output activity counters, sampled just after each edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (vu_pwm[0]) hi0 = hi0 + 1;
        if (!vu_pwm[1]) lo1 = lo1 + 1;
        if (level_valid) vcnt = vcnt + 1;
    end

    // One-cycle strobe; returns at the negedge right after the sampling edge
    task automatic strobe(input logic [7:0] s0, input logic [7:0] s1);
        @(negedge clk);
        audio_samples    = {s1, s0};
        audio_clk_enable = 1'b1;
        @(negedge clk);
        audio_clk_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        audio_clk_enable = 1'b0;
        audio_enable = 1'b0;
        mode = 1'b0;
        audio_samples = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 14'd0) begin errors++; $display("FAIL reset_level: got %0h expected 0", level); end
        checks++;
        if (level_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", level_valid); end
        checks++;
        if (vu_pwm !== 2'b00) begin errors++; $display("FAIL reset_pwm: got %0b expected 0", vu_pwm); end
    endtask

    task automatic test_average_pwm();
        int v0, h, l;
        mode = 1'b0;
        @(negedge clk);
        audio_enable = 1'b1;
        v0 = vcnt;
        for (int i = 0; i < 16; i++) begin
            strobe(8'h40, 8'h80);
            if (i == 14) begin
                checks++;
                if (level_valid !== 1'b0 || level !== 14'd0) begin
                    errors++; $display("FAIL avg_early_close: got valid=%0b level=%0h expected 0/0", level_valid, level);
                end
            end
        end
        checks++;
        if (level_valid !== 1'b1) begin errors++; $display("FAIL avg_valid: got %0b expected 1", level_valid); end
        checks++;
        if (level[6:0] !== 7'd64) begin errors++; $display("FAIL avg_level0: got %0d expected 64", level[6:0]); end
        checks++;
        if (level[13:7] !== 7'd127) begin errors++; $display("FAIL avg_level1_saturate: got %0d expected 127", level[13:7]); end
        repeat (3) @(negedge clk);
        checks++;
        if (vcnt - v0 !== 1) begin errors++; $display("FAIL avg_valid_count: got %0d expected 1", vcnt - v0); end
        repeat (8392) @(negedge clk);
        h = hi0;
        l = lo1;
        repeat (8192) @(negedge clk);
        checks++;
        if (hi0 - h !== 4096) begin errors++; $display("FAIL pwm0_high_time: got %0d expected 4096", hi0 - h); end
        checks++;
        if (lo1 - l !== 64) begin errors++; $display("FAIL pwm1_low_time: got %0d expected 64", lo1 - l); end
    endtask

    task automatic test_mid_period_change();
        int base, rise_cyc;
        logic prev, found;
        prev = vu_pwm[0];
        found = 1'b0;
        for (int i = 0; i < 9000 && !found; i++) begin
            @(negedge clk);
            if (!prev && vu_pwm[0]) found = 1'b1;
            prev = vu_pwm[0];
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_rise_timeout: got no rise expected rise of vu_pwm[0]");
        end else begin
            rise_cyc = cyc;
            base = hi0 - 1;
            repeat (50) @(negedge clk);
            for (int i = 0; i < 16; i++) strobe(8'h20, 8'h80);
            checks++;
            if (level[6:0] !== 7'd32) begin errors++; $display("FAIL mid_level0: got %0d expected 32", level[6:0]); end
            while (cyc < rise_cyc + 8191) @(negedge clk);
            checks++;
            if (hi0 - base !== 4096) begin errors++; $display("FAIL mid_period_old_duty: got %0d expected 4096", hi0 - base); end
            base = hi0;
            repeat (8192) @(negedge clk);
            checks++;
            if (hi0 - base !== 2048) begin errors++; $display("FAIL mid_next_period_duty: got %0d expected 2048", hi0 - base); end
        end
    endtask

    task automatic test_reset_mid_period();
        int h, l, v0;
        checks++;
        if (level[13:7] !== 7'd127) begin errors++; $display("FAIL rst_pre_level1: got %0d expected 127", level[13:7]); end
        repeat (1000) @(negedge clk);
        v0 = vcnt;
        reset = 1'b1;
        audio_samples = 16'h7F7F;
        audio_clk_enable = 1'b1;
        @(negedge clk);
        checks++;
        if (vu_pwm !== 2'b00) begin errors++; $display("FAIL rst_mid_pwm: got %0b expected 0", vu_pwm); end
        checks++;
        if (level !== 14'd0) begin errors++; $display("FAIL rst_mid_level: got %0h expected 0", level); end
        checks++;
        if (level_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b expected 0", level_valid); end
        @(negedge clk);
        reset = 1'b0;
        audio_clk_enable = 1'b0;
        h = hi0;
        l = lo1;
        repeat (9000) @(negedge clk);
        checks++;
        if (hi0 - h !== 0 || lo1 - l !== 9000) begin
            errors++; $display("FAIL rst_pwm_stays_low: got hi0=%0d lo1=%0d expected 0/9000", hi0 - h, lo1 - l);
        end
        checks++;
        if (level !== 14'd0 || vcnt != v0) begin
            errors++; $display("FAIL rst_level_stays_zero: got level=%0h pulses=%0d expected 0/0", level, vcnt - v0);
        end
    endtask

    task automatic test_peak_decay();
        mode = 1'b1;
        strobe(8'd100, 8'h9C);
        for (int i = 1; i < 16; i++) strobe(8'h00, 8'h00);
        checks++;
        if (level_valid !== 1'b1 || level[6:0] !== 7'd100 || level[13:7] !== 7'd100) begin
            errors++; $display("FAIL peak_capture: got valid=%0b l0=%0d l1=%0d expected 1/100/100", level_valid, level[6:0], level[13:7]);
        end
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < 16; i++) strobe(8'h00, 8'h00);
            checks++;
            if (level[6:0] !== 7'(100 - w) || level[13:7] !== 7'(100 - w)) begin
                errors++; $display("FAIL peak_decay_w%0d: got l0=%0d l1=%0d expected %0d", w, level[6:0], level[13:7], 100 - w);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 8) mode = 1'b0;
            if (i == 0) strobe(8'd100, 8'h9C);
            else strobe(8'h00, 8'h00);
        end
        checks++;
        if (level[6:0] !== 7'd6 || level[13:7] !== 7'd6) begin
            errors++; $display("FAIL mode_switch_avg: got l0=%0d l1=%0d expected 6", level[6:0], level[13:7]);
        end
        for (int i = 0; i < 16; i++) strobe(8'h00, 8'h00);
        checks++;
        if (level[6:0] !== 7'd0 || level[13:7] !== 7'd0) begin
            errors++; $display("FAIL avg_zero_window: got l0=%0d l1=%0d expected 0", level[6:0], level[13:7]);
        end
    endtask

    task automatic test_enable_drop();
        int v0;
        mode = 1'b0;
        for (int i = 0; i < 16; i++) strobe(8'h40, 8'h40);
        checks++;
        if (level !== {7'd64, 7'd64}) begin errors++; $display("FAIL drop_pre_level: got %0h expected %0h", level, {7'd64, 7'd64}); end
        @(negedge clk);
        v0 = vcnt;
        for (int i = 0; i < 8; i++) strobe(8'h7F, 8'h7F);
        @(negedge clk);
        audio_samples = 16'h7F7F;
        audio_clk_enable = 1'b1;
        audio_enable = 1'b0;
        @(negedge clk);
        audio_clk_enable = 1'b0;
        checks++;
        if (level !== 14'd0 || level_valid !== 1'b0) begin
            errors++; $display("FAIL drop_clear: got level=%0h valid=%0b expected 0/0", level, level_valid);
        end
        for (int i = 0; i < 4; i++) strobe(8'h7F, 8'h7F);
        checks++;
        if (level !== 14'd0 || vcnt != v0) begin
            errors++; $display("FAIL drop_idle: got level=%0h pulses=%0d expected 0/0", level, vcnt - v0);
        end
        @(negedge clk);
        audio_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            strobe(8'h10, 8'h08);
            if (i == 14) begin
                checks++;
                if (level_valid !== 1'b0 || level !== 14'd0) begin
                    errors++; $display("FAIL drop_early_close: got valid=%0b level=%0h expected 0/0", level_valid, level);
                end
            end
        end
        checks++;
        if (level_valid !== 1'b1 || level[6:0] !== 7'd16 || level[13:7] !== 7'd8) begin
            errors++; $display("FAIL drop_post_avg: got valid=%0b l0=%0d l1=%0d expected 1/16/8", level_valid, level[6:0], level[13:7]);
        end
    endtask

    initial begin
        test_reset();
        test_average_pwm();
        test_mid_period_change();
        test_reset_mid_period();
        test_peak_decay();
        test_enable_drop();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
